rv_mem_responder: RTL and testbench

Word-addressed on-chip memory that serves as the responder end of the priRV32 core's memory request interface. It accepts one request at a time from the core over a valid/ready request channel. It performs a read or a byte-masked write after a configurable number of wait states, then returns the result on a valid/ready response channel. Misaligned or out-of-range accesses are rejected with an error response.

---
 rtl/rv_mem_responder.sv | 145 ++++++++++++++
 tb/tb_rv_mem_responder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_responder.sv
// Word-addressed on-chip memory answering the core's valid/ready request channel.
// One transaction at a time: accept, wait WAIT_CYCLES, access, then hold the response until taken.
module rv_mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic        alive_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic              acc_en;
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_wstrb;
  logic              acc_err;
  logic [ADDR_W-3:0] acc_idx;

  // With zero wait states the access happens on the accepting edge, so it uses the live inputs.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wstrb = wstrb_q;
    if (state_q == ST_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end
    acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> ADDR_W) != 32'd0);
    acc_idx = acc_addr[ADDR_W-1:2];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    acc_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = alive_q;
        if (req_valid && alive_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (WAIT_CYCLES == 0) begin
            acc_en  = 1'b1;
            cnt_d   = 4'd0;
            state_d = ST_RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          acc_en  = 1'b1;
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // alive_q keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      alive_q <= 1'b0;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      if (acc_en) begin
        err_q   <= acc_err;
        rdata_q <= (!acc_err && !acc_we) ? mem[acc_idx] : 32'd0;
      end
    end
  end

  // Memory array is deliberately outside reset so its contents survive it.
  always_ff @(posedge clk_in) begin
    if (acc_en && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_rv_mem_responder.sv
// Bench for rv_mem_responder: two instances (2 and 0 wait states) checked every cycle
// against a transaction-level reference model, plus directed literal expectations.
module tb_rv_mem_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_wstrb  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int checks   = 0;
  int failures = 0;

  rv_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(W0)) u_dut0 (
    .clk_in(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  rv_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(W1)) u_dut1 (
    .clk_in(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
  endfunction

  function automatic int wait_of(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  // ---------------- transaction-level reference model ----------------
  logic [31:0] ref_mem [2][1024];
  bit          known   [2][1024];
  bit          busy    [2];
  int          due     [2];
  bit          p_we    [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];
  logic [3:0]  p_wstrb [2];
  logic [31:0] e_rdata [2];
  bit          e_err   [2];
  bit          e_known [2];
  bit          prev_rst = 1'b0;
  int          cyc = 0;

  task automatic model_step(input int i);
    bit alive, ready_e, valid_e;
    int idx;
    if (!rst_n) begin
      check($sformatf("rst_req_ready%0d", i), req_ready[i], 0);
      check($sformatf("rst_resp_valid%0d", i), resp_valid[i], 0);
      check($sformatf("rst_rdata%0d", i), resp_rdata[i], 0);
      check($sformatf("rst_err%0d", i), resp_err[i], 0);
      busy[i] = 0; e_rdata[i] = 0; e_err[i] = 0; e_known[i] = 1;
    end else begin
      alive   = prev_rst;
      ready_e = alive && !busy[i];
      valid_e = busy[i] && (cyc >= due[i]);
      if (busy[i] && cyc == due[i]) begin
        idx = int'(p_addr[i][11:2]);
        if (addr_bad(p_addr[i])) begin
          e_rdata[i] = 0; e_err[i] = 1; e_known[i] = 1;
        end else if (p_we[i]) begin
          for (int b = 0; b < 4; b++)
            if (p_wstrb[i][b]) ref_mem[i][idx][8*b +: 8] = p_wdata[i][8*b +: 8];
          if (p_wstrb[i] == 4'hF) known[i][idx] = 1;
          e_rdata[i] = 0; e_err[i] = 0; e_known[i] = 1;
        end else begin
          e_rdata[i] = ref_mem[i][idx]; e_err[i] = 0; e_known[i] = known[i][idx];
        end
      end
      check($sformatf("req_ready%0d@%0d", i, cyc), req_ready[i], ready_e);
      check($sformatf("resp_valid%0d@%0d", i, cyc), resp_valid[i], valid_e);
      check($sformatf("resp_err%0d@%0d", i, cyc), resp_err[i], e_err[i]);
      if (e_known[i]) check($sformatf("resp_rdata%0d@%0d", i, cyc), resp_rdata[i], e_rdata[i]);
      if (req_valid[i] && ready_e) begin
        busy[i] = 1; due[i] = cyc + wait_of(i) + 1;
        p_we[i] = req_we[i]; p_addr[i] = req_addr[i];
        p_wdata[i] = req_wdata[i]; p_wstrb[i] = req_wstrb[i];
      end
      if (valid_e && resp_ready[i]) busy[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    model_step(0);
    model_step(1);
    prev_rst = rst_n;
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_txn(input int i, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, input bit bp,
                        output logic [31:0] rd, output bit er, output int lat);
    bit hs, done;
    int t, k;
    rd = 0; er = 0; lat = -1; hs = 0; done = 0; t = 0; k = 0;
    @(posedge clk); #1;
    req_valid[i] = 1; req_we[i] = we; req_addr[i] = addr;
    req_wdata[i] = wdata; req_wstrb[i] = wstrb;
    resp_ready[i] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!hs && t < 40) begin
      @(negedge clk);
      if (req_ready[i]) hs = 1;
      else begin @(posedge clk); #1; end
      t++;
    end
    if (!hs) begin
      timeout_fail("handshake");
      req_valid[i] = 0;
    end else begin
      while (!done && k < 60) begin
        @(posedge clk); #1;
        req_valid[i] = 0;
        if (bp) resp_ready[i] = 1'($urandom_range(0, 1));
        @(negedge clk);
        k++;
        if (resp_valid[i]) begin
          if (lat < 0) lat = k;
          rd = resp_rdata[i]; er = resp_err[i];
          if (resp_ready[i]) done = 1;
        end
      end
      if (!done) timeout_fail("response");
    end
  endtask

  logic [31:0] rd;
  bit          er;
  int          lat;
  logic [31:0] bval [8];
  int          hs_c [8];
  int          rs_c [8];

  initial begin
    bit ok, hs_now;
    int n, k, rc;
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_we[i] = 0; req_addr[i] = 0;
      req_wdata[i] = 0; req_wstrb[i] = 0; resp_ready[i] = 1;
    end
    for (int j = 0; j < 8; j++) begin hs_c[j] = 0; rs_c[j] = 0; end

    // reset release
    repeat (3) @(posedge clk); #1;
    check("ready_in_reset", req_ready[0], 0);
    rst_n = 1; #1;
    check("ready_after_release", req_ready[0], 0);
    @(posedge clk); #1;
    check("ready_first_edge", req_ready[0], 1);

    // write then read, 3-cycle latency
    do_txn(0, 1, 32'h010, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    check("wr_lat", lat, 3); check("wr_err", er, 0); check("wr_rdata", rd, 0);
    do_txn(0, 0, 32'h010, 32'h0, 4'h0, 0, rd, er, lat);
    check("rd_lat", lat, 3); check("rd_err", er, 0); check("rd_data", rd, 32'hDEADBEEF);

    // byte strobes
    do_txn(0, 1, 32'h020, 32'h11223344, 4'hF, 0, rd, er, lat);
    do_txn(0, 1, 32'h020, 32'hAABBCCDD, 4'h5, 0, rd, er, lat);
    do_txn(0, 0, 32'h020, 32'h0, 4'h0, 0, rd, er, lat);
    check("strobe_data", rd, 32'h11BB33DD);

    // errors
    do_txn(0, 1, 32'h000, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
    do_txn(0, 0, 32'h002, 32'h0, 4'h0, 0, rd, er, lat);
    check("misalign_err", er, 1); check("misalign_rdata", rd, 0);
    do_txn(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
    check("range_err", er, 1);
    do_txn(0, 0, 32'h000, 32'h0, 4'h0, 0, rd, er, lat);
    check("after_err_data", rd, 32'hCAFEF00D); check("after_err_err", er, 0);

    // response backpressure with a held request behind it
    @(posedge clk); #1;
    req_valid[0] = 1; req_we[0] = 0; req_addr[0] = 32'h010; resp_ready[0] = 0;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); ok = req_ready[0]; end
    if (!ok) timeout_fail("bp_handshake");
    @(posedge clk); #1; req_valid[0] = 0;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); ok = resp_valid[0]; end
    if (!ok) timeout_fail("bp_resp");
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      if (j == 0) begin
        req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h044;
        req_wdata[0] = 32'h12345678; req_wstrb[0] = 4'hF;
      end
      @(negedge clk);
      check("bp_valid_held", resp_valid[0], 1);
      check("bp_rdata_held", resp_rdata[0], 32'hDEADBEEF);
      check("bp_ready_low", req_ready[0], 0);
    end
    @(posedge clk); #1; resp_ready[0] = 1;
    @(negedge clk);
    check("bp_release_valid", resp_valid[0], 1);
    check("bp_release_ready", req_ready[0], 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_held_accept", req_ready[0], 1);
    @(posedge clk); #1; req_valid[0] = 0;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); ok = resp_valid[0]; end
    if (!ok) timeout_fail("bp_held_resp");
    do_txn(0, 0, 32'h044, 32'h0, 4'h0, 0, rd, er, lat);
    check("bp_held_write", rd, 32'h12345678);

    // zero wait states: preload then 8 back-to-back reads
    for (int j = 0; j < 8; j++) begin
      bval[j] = 32'h1000_0000 + j * 32'h0101_0101;
      do_txn(1, 1, 32'h040 + 4 * j, bval[j], 4'hF, 0, rd, er, lat);
      if (j == 0) check("w0_lat", lat, 1);
    end
    resp_ready[1] = 1; k = 0; rc = 0; n = 0;
    @(posedge clk); #1;
    req_valid[1] = 1; req_we[1] = 0; req_addr[1] = 32'h040;
    while (rc < 8 && n < 80) begin
      @(negedge clk);
      n++; hs_now = 0;
      if (req_valid[1] && req_ready[1]) begin hs_c[k] = n; hs_now = 1; end
      if (resp_valid[1]) begin
        rs_c[rc] = n;
        check($sformatf("burst_data%0d", rc), resp_rdata[1], bval[rc]);
        rc++;
      end
      @(posedge clk); #1;
      if (hs_now) begin
        k++;
        if (k < 8) req_addr[1] = 32'h040 + 4 * k;
        else req_valid[1] = 0;
      end
    end
    req_valid[1] = 0;
    if (rc < 8) timeout_fail("burst");
    for (int j = 0; j < 8; j++) check($sformatf("burst_lat%0d", j), rs_c[j] - hs_c[j], 1);
    for (int j = 0; j < 7; j++) check($sformatf("burst_period%0d", j), hs_c[j+1] - hs_c[j], 2);

    // reset during the wait phase of a write
    do_txn(0, 1, 32'h030, 32'h01020304, 4'hF, 0, rd, er, lat);
    do_txn(0, 0, 32'h030, 32'h0, 4'h0, 0, rd, er, lat);
    check("pre_reset_data", rd, 32'h01020304);
    @(posedge clk); #1;
    req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h030;
    req_wdata[0] = 32'h55AA55AA; req_wstrb[0] = 4'hF;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); ok = req_ready[0]; end
    if (!ok) timeout_fail("mid_reset_handshake");
    @(posedge clk); #1;
    req_valid[0] = 0; rst_n = 0; #1;
    check("mid_rst_valid", resp_valid[0], 0);
    check("mid_rst_ready", req_ready[0], 0);
    check("mid_rst_rdata", resp_rdata[0], 0);
    check("mid_rst_err", resp_err[0], 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    do_txn(0, 0, 32'h030, 32'h0, 4'h0, 0, rd, er, lat);
    check("mid_rst_mem", rd, 32'h01020304);

    // randomized traffic with random response backpressure
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 40; j++) begin
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 15);
        if (r < 12)       a = 32'h080 + 4 * (r % 8);
        else if (r == 12) a = 32'h080 + 32'($urandom_range(1, 3));
        else if (r == 13) a = 32'h1000 + 4 * 32'($urandom_range(0, 15));
        else if (r == 14) a = 32'h8000_0000;
        else              a = 32'h3FC;
        do_txn(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1, rd, er, lat);
        check($sformatf("rand_lat%0d_%0d", i, j), lat, wait_of(i) + 1);
      end
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
